// File: rtl/rnn_node_pkg.sv
// Shared constants and controller state type for the RNN node RAM, its
// controller and the MAC datapath.
package rnn_node_pkg;

  localparam int ADDR_W  = 9;
  localparam int RAMSIZE = 512;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SWEEP = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/rnn_ram_ctrl.sv
// Owns the RNN parameter/state RAM ports: arbitrates host loads, whole-RAM
// clears and compute sweeps, and tags registered read data for the MAC.
module rnn_ram_ctrl #(
  parameter int ADDR_W  = rnn_node_pkg::ADDR_W,
  parameter int RAMSIZE = rnn_node_pkg::RAMSIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              pause,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_clr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err_len
);
  import rnn_node_pkg::*;

  localparam logic [ADDR_W:0] MaxLen = (ADDR_W+1)'(RAMSIZE);
  localparam logic [ADDR_W:0] One    = (ADDR_W+1)'(1);

  ctrl_state_t       state_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [ADDR_W-1:0] outIdx_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   len_q;
  logic              issue_q;
  logic              clr_q;
  logic              outValid_q;
  logic              outLast_q;
  logic              done_q;
  logic              errLen_q;
  logic              lenOk;

  assign lenOk     = (len != '0) && (len <= MaxLen);
  assign ld_ready  = (state_q == IDLE) && !clear && !start && reset;
  assign ram_we    = ld_valid && ld_ready;
  assign ram_waddr = ld_addr;
  assign busy      = (state_q != IDLE);

  assign ram_raddr = raddr_q;
  assign ram_clr   = clr_q;
  assign out_valid = outValid_q;
  assign out_idx   = outIdx_q;
  assign out_last  = outLast_q;
  assign done      = done_q;
  assign err_len   = errLen_q;

  // cnt_q counts addresses issued so far, one bit wider than the address so
  // a full-depth sweep ends on the count rather than on an address wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      raddr_q    <= '0;
      outIdx_q   <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      issue_q    <= 1'b0;
      clr_q      <= 1'b0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      done_q     <= 1'b0;
      errLen_q   <= 1'b0;
    end else begin
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
      errLen_q   <= 1'b0;
      outValid_q <= issue_q;
      outIdx_q   <= raddr_q;
      outLast_q  <= issue_q && (cnt_q == len_q);
      case (state_q)
        IDLE: begin
          if (clear) begin
            state_q <= CLEAR;
            clr_q   <= 1'b1;
          end else if (start) begin
            if (lenOk) begin
              len_q   <= len;
              raddr_q <= '0;
              cnt_q   <= One;
              issue_q <= 1'b1;
              state_q <= SWEEP;
            end else begin
              errLen_q <= 1'b1;
            end
          end
        end
        CLEAR: state_q <= IDLE;
        SWEEP: begin
          if (cnt_q == len_q) begin
            issue_q <= 1'b0;
            state_q <= DRAIN;
          end else if (pause) begin
            issue_q <= 1'b0;
          end else begin
            raddr_q <= raddr_q + 1'b1;
            cnt_q   <= cnt_q + 1'b1;
            issue_q <= 1'b1;
          end
        end
        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_ram_ctrl.sv
// Directed bench for rnn_ram_ctrl with a behavioural RAM and a scoreboard of
// expected sweep outputs (index, last flag, read data).
module tb_rnn_ram_ctrl;

  localparam int AW = 9;

  typedef struct {
    logic [AW-1:0] idx;
    logic          last;
    logic [15:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, clear, start, pause, ld_valid;
  logic [AW:0]   len;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ldData;
  logic          ld_ready, ram_we, ram_clr, out_valid, out_last, busy, done, err_len;
  logic [AW-1:0] ram_waddr, ram_raddr, out_idx;

  logic [15:0] mem    [0:511];
  logic [15:0] expMem [0:511];
  logic [15:0] rdata;
  exp_t        sbq [$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          lastCycle = -10;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  rnn_ram_ctrl dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .len(len),
    .pause(pause), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_clr(ram_clr), .out_valid(out_valid), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done), .err_len(err_len)
  );

  // Behavioural RAM: synchronous write, synchronous clear, registered read.
  always @(posedge clk) begin
    if (ram_clr === 1'b1) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
    end else if (ram_we === 1'b1) begin
      mem[ram_waddr] <= ldData;
    end
    rdata <= mem[ram_raddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushSweep(input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.idx  = AW'(i);
      x.last = (i == n - 1);
      x.data = expMem[i];
      sbq.push_back(x);
    end
  endtask

  task automatic waitDone(input string tag, input int bound);
    int seen = 0;
    int dc = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        dc = cycle;
        break;
      end
    end
    checkOutput({tag, "_done_seen"}, seen, 1);
    checkOutput({tag, "_sb_drained"}, sbq.size(), 0);
    checkOutput({tag, "_done_after_last"}, dc, lastCycle + 1);
    step();
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, done, 0);
    checkOutput({tag, "_idle_busy"}, busy, 0);
    step();
  endtask

  // Scoreboard consumer: every valid output must match the next expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      checkOutput("sb_has_entry", (sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checkOutput("out_idx", out_idx, e.idx);
        checkOutput("out_last", out_last, e.last);
        checkOutput("ram_data", rdata, e.data);
        if (out_last === 1'b1) lastCycle = cycle;
      end
    end else if (reset === 1'b1) begin
      checkOutput("last_without_valid", out_last, 0);
    end
  end

  initial begin
    reset = 1'b0; clear = 1'b0; start = 1'b1; pause = 1'b0; ld_valid = 1'b1;
    len = 10'd3; ld_addr = '0; ldData = '0;

    // Reset hold with start and load requests asserted.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst_ld_ready", ld_ready, 0);
      checkOutput("rst_ram_we", ram_we, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_raddr", ram_raddr, 0);
      checkOutput("rst_clr", ram_clr, 0);
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_idx", out_idx, 0);
      checkOutput("rst_last", out_last, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err_len, 0);
    end
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0;
    #1;
    checkOutput("rel_ld_ready", ld_ready, 1);
    checkOutput("rel_busy", busy, 0);
    step();
    @(negedge clk);
    checkOutput("rel_valid", out_valid, 0);
    step();

    // Back-to-back host loads, then a 3-entry sweep.
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_addr = AW'(i); ldData = 16'h1000 + 16'(i) * 16'h0111;
      expMem[i] = ldData;
      @(negedge clk);
      checkOutput("load_ready", ld_ready, 1);
      checkOutput("load_we", ram_we, 1);
      checkOutput("load_waddr", ram_waddr, i);
      step();
    end
    ld_valid = 1'b0;
    start = 1'b1; len = 10'd3;
    pushSweep(3);
    @(negedge clk);
    checkOutput("start_blocks_load", ld_ready, 0);
    step();
    start = 1'b0;
    @(negedge clk);
    checkOutput("s3_raddr0", ram_raddr, 0);
    checkOutput("s3_busy", busy, 1);
    checkOutput("s3_busy_ready", ld_ready, 0);
    step();
    @(negedge clk);
    checkOutput("s3_raddr1", ram_raddr, 1);
    step();
    @(negedge clk);
    checkOutput("s3_raddr2", ram_raddr, 2);
    waitDone("s3", 20);

    // Pause for two cycles right after address 1 is issued.
    for (int i = 3; i < 4; i++) expMem[i] = mem[i];
    ld_valid = 1'b1; ld_addr = 9'd3; ldData = 16'h4444; expMem[3] = 16'h4444;
    step();
    ld_valid = 1'b0;
    start = 1'b1; len = 10'd4;
    pushSweep(4);
    step();
    start = 1'b0;
    @(negedge clk);
    checkOutput("p_raddr0", ram_raddr, 0);
    step();
    pause = 1'b1;
    @(negedge clk);
    checkOutput("p_raddr1", ram_raddr, 1);
    step();
    @(negedge clk);
    checkOutput("p_hold_a", ram_raddr, 1);
    checkOutput("p_valid_idx1", out_valid, 1);
    step();
    pause = 1'b0;
    @(negedge clk);
    checkOutput("p_hold_b", ram_raddr, 1);
    checkOutput("p_gap_a", out_valid, 0);
    step();
    @(negedge clk);
    checkOutput("p_resume", ram_raddr, 2);
    checkOutput("p_gap_b", out_valid, 0);
    waitDone("pause", 20);

    // Illegal lengths at both ends.
    start = 1'b1; len = 10'd0;
    step();
    start = 1'b0;
    @(negedge clk);
    checkOutput("len0_err", err_len, 1);
    checkOutput("len0_busy", busy, 0);
    step();
    @(negedge clk);
    checkOutput("len0_err_pulse", err_len, 0);
    checkOutput("len0_valid", out_valid, 0);
    step();
    start = 1'b1; len = 10'd513;
    step();
    start = 1'b0;
    @(negedge clk);
    checkOutput("len513_err", err_len, 1);
    checkOutput("len513_busy", busy, 0);
    step();
    @(negedge clk);
    checkOutput("len513_err_pulse", err_len, 0);
    checkOutput("len513_valid", out_valid, 0);
    step();

    // Clear wins over start and load in the same cycle.
    clear = 1'b1; start = 1'b1; len = 10'd2; ld_valid = 1'b1; ld_addr = 9'd1; ldData = 16'hBEEF;
    @(negedge clk);
    checkOutput("prio_ready", ld_ready, 0);
    checkOutput("prio_we", ram_we, 0);
    step();
    clear = 1'b0; start = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < 512; i++) expMem[i] = '0;
    @(negedge clk);
    checkOutput("clr_pulse", ram_clr, 1);
    checkOutput("clr_busy", busy, 1);
    checkOutput("clr_no_sweep", out_valid, 0);
    step();
    @(negedge clk);
    checkOutput("clr_pulse_end", ram_clr, 0);
    checkOutput("clr_idle", busy, 0);
    step();
    start = 1'b1; len = 10'd2;
    pushSweep(2);
    step();
    start = 1'b0;
    waitDone("zero2", 20);

    // Fill the whole RAM, then abandon a full sweep with reset.
    for (int i = 0; i < 512; i++) begin
      ld_valid = 1'b1; ld_addr = AW'(i); ldData = 16'(i * 37 + 5) ^ 16'hA500;
      expMem[i] = ldData;
      step();
    end
    ld_valid = 1'b0;
    start = 1'b1; len = 10'd512;
    pushSweep(512);
    step();
    start = 1'b0;
    repeat (9) step();
    @(negedge clk);
    checkOutput("mid_raddr9", ram_raddr, 9);
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_raddr", ram_raddr, 0);
    checkOutput("mid_rst_done", done, 0);
    reset = 1'b1;
    sbq.delete();
    step();
    @(negedge clk);
    checkOutput("mid_rel_valid", out_valid, 0);
    checkOutput("mid_rel_done", done, 0);
    checkOutput("mid_rel_ready", ld_ready, 1);
    step();

    // Full-depth sweep must end at 511 without wrapping.
    start = 1'b1; len = 10'd512;
    pushSweep(512);
    step();
    start = 1'b0;
    waitDone("full512", 600);
    checkOutput("full512_final_idx", e.idx, 511);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rnn_ram_ctrl.md
Name: rnn_ram_ctrl

Overview:
Controller sequencing the RNN node's parameter/state RAM (W, H, U, X, V banks sharing one write port and one read port). It arbitrates host loads, whole-RAM clears and compute sweeps, since only one may own the RAM at a time. A sweep issues read addresses 0..len-1, one per cycle, and tags the RAM's registered read data with valid, index and last flags for the downstream MAC datapath. Host write data goes straight to the RAM data inputs. This block drives only the RAM's write-enable, addresses and clear.

Parameters:
ADDR_W, 9, RAM address width
RAMSIZE, 512, RAM depth; legal sweep length is 1..RAMSIZE

Ports:
clk  in  1  clock; all logic is on its rising edge
reset  in  1  synchronous, active-low reset
clear  in  1  request a one-cycle clear of the whole RAM
start  in  1  request a sweep of len entries
len  in  ADDR_W+1  sweep length, sampled when start is accepted
pause  in  1  while high during a sweep, no new address is issued
ld_valid  in  1  host write request
ld_addr  in  ADDR_W  host write address
ld_ready  out  1  host write accepted this cycle when ld_valid&ld_ready
ram_we  out  1  to RAM writeenable
ram_waddr  out  ADDR_W  to RAM writeport
ram_raddr  out  ADDR_W  to RAM readport (registered)
ram_clr  out  1  to RAM reset (active-high, registered)
out_valid  out  1  RAM read outputs hold data for out_idx this cycle
out_idx  out  ADDR_W  address of the data now on the RAM outputs
out_last  out  1  with out_valid: final entry of the sweep
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse at sweep completion
err_len  out  1  one-cycle pulse when start is rejected for an illegal len

Behaviour:
- States: IDLE, CLEAR, SWEEP, DRAIN, DONE. Encoding is a 3-bit enum.
- Reset (reset==0 at a posedge): state goes to IDLE. All registered outputs go to 0: ram_raddr, ram_clr, out_valid, out_idx, out_last, done, err_len, issue pipe and counter.
- While reset==0, ld_ready and ram_we are forced to 0.
- Reset mid-sweep abandons the sweep with no done pulse. The cycle after reset is released, out_valid is 0.
- IDLE priority is clear > start > load.
  - ld_ready = (state==IDLE) & ~clear & ~start & reset.
  - ram_we = ld_valid & ld_ready and ram_waddr = ld_addr, both combinational. The write lands at that posedge.
- clear in IDLE: go to CLEAR. ram_clr is 1 for exactly the one cycle in CLEAR, then the state returns to IDLE. Clear takes 2 cycles from request to IDLE.
- start in IDLE with len==0 or len>RAMSIZE: err_len is pulsed for 1 cycle and the state stays IDLE.
- start in IDLE with a legal len: latch len, set ram_raddr=0 and issue=1, go to SWEEP.
- SWEEP, issue path:
  - issue is registered and is high when ram_raddr holds a fresh address.
  - Each cycle with pause==0, ram_raddr increments and issue=1.
  - Each cycle with pause==1, ram_raddr holds and issue=0. Re-reading the held address is harmless.
  - After address len-1 has been issued, go to DRAIN.
- SWEEP, output path:
  - out_valid = issue delayed by 1 cycle.
  - out_idx = ram_raddr delayed by 1 cycle.
  - out_last = out_valid & (out_idx==len-1).
  - Required latency: start accepted at edge t, so address 0 is held in cycle t; RAM data for it is visible with out_valid=1 in cycle t+1.
- DRAIN: one cycle, in which the final out_valid/out_last is presented. The state then goes to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in CLEAR, SWEEP, DRAIN and DONE.
- clear, start and ld_valid while busy are ignored (not queued), and ld_ready=0.
- len==RAMSIZE: the counter must not wrap before the last issue. The ADDR_W+1-bit len is compared against the issued count.

Decomposition:
- Package rnn_node_pkg holds ADDR_W, RAMSIZE and the ctrl_state_t enum, shared with the RAM and the MAC datapath.
- No sub-module: the address counter and output pipe are a handful of registers and stay inline.

Test Plan:
- Reset hold: reset=0 for 3 cycles with start=1 and ld_valid=1 -> every output is 0, including ld_ready=0 and ram_we=0. After release, ld_ready=1 and busy=0.
- Load then sweep: write addr 0,1,2 on back-to-back cycles (ram_we=1 each), then start with len=3 -> ram_raddr=0,1,2 on consecutive cycles; out_valid=1 with out_idx=0,1,2 one cycle later each; out_last only at idx 2; done pulses the cycle after out_last; RAM data matches what was loaded.
- Pause: len=4 with pause=1 for 2 cycles after idx 1 is issued -> ram_raddr holds at 1, out_valid drops for 2 cycles, the sequence resumes at 2,3, and no index is duplicated or lost.
- Illegal length: start with len=0 and then len=513 -> one err_len pulse each, busy stays 0, no reads are issued.
- Priority and clear: clear, start and ld_valid all in the same IDLE cycle -> only CLEAR is taken, ram_clr=1 for exactly 1 cycle, ram_we=0. A following sweep with len=2 reads all-zero data.
- Mid-sweep reset: len=512 with reset=0 after 10 issues -> IDLE the next cycle, no done pulse. A subsequent len=512 sweep completes with out_last at idx 511 and no wrap.
